// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and helpers for the FIFO read-port arbiter.
// The arbiter arbitrates at most MAX_REQ consumers; helpers are sized for that.
package fifo_rd_arb_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Burst counter width. One spare bit keeps BURST_LEN-1 representable
  // for every legal BURST_LEN, including 1.
  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

  // Index of the set bit of a one-hot vector (zero for an all-zero input).
  // OR-reduction form keeps it a plain mux tree.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_pick.sv
// Combinational rotating-priority picker: grants the first requester found
// walking the ring upward from i_start, wrapping at NUM_REQ-1.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_start,
  output logic [NUM_REQ-1:0]         o_win,
  output logic                       o_any
);

  localparam int              IDXW = $clog2(NUM_REQ);
  localparam logic [IDXW-1:0] LAST = IDXW'(NUM_REQ - 1);

  // Walk the ring once from i_start and keep only the first requester seen.
  always_comb begin
    logic [IDXW-1:0] w_idx;
    logic            w_found;
    o_win   = '0;
    w_found = 1'b0;
    w_idx   = i_start;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req[w_idx]) begin
        o_win[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
      w_idx = (w_idx == LAST) ? '0 : w_idx + IDXW'(1);
    end
    o_any = |i_req;
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-port arbiter for the asynchronous FIFO (read clock domain).
// Shares the single first-word-fall-through pop interface among NUM_REQ
// consumers with round-robin grants held for bursts of at most BURST_LEN pops.
// Optional feature macro: FIFO_RD_ARB_PRIO0_EN -- consumer 0 wins every
// arbitration it takes part in and its bursts do not advance the round-robin
// pointer. Undefined (default): pure round-robin.
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  i_r_clk,
  input  logic                  i_rst_n,
  input  logic                  i_r_empty,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ-1:0]    i_rdy,
  output logic                  o_r_inc,
  output logic [NUM_REQ-1:0]    o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [NUM_REQ-1:0]    o_gnt,
  output logic                  o_busy
);

  localparam int              IDXW      = $clog2(NUM_REQ);
  localparam int              CW        = cnt_width(BURST_LEN);
  localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_REQ - 1);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(BURST_LEN - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  w_gnt_nxt;
  logic [IDXW-1:0]     r_rr_ptr;
  logic [IDXW-1:0]     w_rr_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;

  logic [NUM_REQ-1:0]  w_rr_win;
  logic                w_rr_any;
  logic [NUM_REQ-1:0]  w_win;
  logic                w_rr_upd;
  logic [MAX_REQ-1:0]  w_gnt_wide;
  logic [IDXW-1:0]     w_g;
  logic                w_vld;
  logic                w_xfer;
  logic                w_exit;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_start (r_rr_ptr),
    .o_win   (w_rr_win),
    .o_any   (w_rr_any)
  );

`ifdef FIFO_RD_ARB_PRIO0_EN
  // Consumer 0 pre-empts the rotation; its own bursts leave the pointer alone
  // so the other consumers keep their round-robin order.
  assign w_win    = i_req[0] ? NUM_REQ'(1) : w_rr_win;
  assign w_rr_upd = (w_g != '0);
`else
  assign w_win    = w_rr_win;
  assign w_rr_upd = 1'b1;
`endif

  // Decode the registered one-hot grant into the granted consumer's index.
  always_comb begin
    w_gnt_wide              = '0;
    w_gnt_wide[NUM_REQ-1:0] = r_gnt;
    w_g                     = IDXW'(onehot_to_idx(w_gnt_wide));
  end

  // Handshake of the granted consumer and the burst termination condition.
  always_comb begin
    w_vld  = (r_state == ST_BURST) && i_req[w_g] && !i_r_empty;
    w_xfer = w_vld && i_rdy[w_g];
    w_exit = (r_state == ST_BURST) &&
             ((w_xfer && (r_cnt == LAST_BEAT)) || !i_req[w_g] || i_r_empty);
  end

  // State register: FSM state, grant, round-robin pointer and burst count.
  always_ff @(posedge i_r_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Next-state logic: arbitrate in IDLE, count pops and detect exit in BURST.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_rr_nxt    = r_rr_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        // Granting only with data present avoids an empty, useless burst.
        if (w_rr_any && !i_r_empty) begin
          w_state_nxt = ST_BURST;
          w_gnt_nxt   = w_win;
          w_cnt_nxt   = '0;
        end
      end
      ST_BURST: begin
        if (w_exit) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_cnt_nxt   = '0;
          if (w_rr_upd) begin
            w_rr_nxt = (w_g == LAST_IDX) ? '0 : w_g + IDXW'(1);
          end
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic: valid and pop strobe only toward the granted consumer.
  always_comb begin
    o_valid = '0;
    o_r_inc = 1'b0;
    o_busy  = 1'b0;
    if (r_state == ST_BURST) begin
      o_valid = r_gnt & {NUM_REQ{w_vld}};
      o_r_inc = w_xfer;
      o_busy  = 1'b1;
    end
  end

  assign o_gnt  = r_gnt;
  assign o_data = i_rd_data;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: directed scenarios plus a random
// run, all compared against a transaction-level model of the arbitration rules.
module tb_fifo_rd_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int BURST_LEN  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  r_empty;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    rdy;
  logic                  r_inc;
  logic [NUM_REQ-1:0]    valid;
  logic [DATA_WIDTH-1:0] data;
  logic [NUM_REQ-1:0]    gnt;
  logic                  busy;

  always #5 clk = ~clk;

  fifo_rd_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_WIDTH (DATA_WIDTH),
    .BURST_LEN  (BURST_LEN)
  ) dut (
    .i_r_clk   (clk),
    .i_rst_n   (rst_n),
    .i_r_empty (r_empty),
    .i_rd_data (rd_data),
    .i_req     (req),
    .i_rdy     (rdy),
    .o_r_inc   (r_inc),
    .o_valid   (valid),
    .o_data    (data),
    .o_gnt     (gnt),
    .o_busy    (busy)
  );

  logic [DATA_WIDTH-1:0] fifo_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit prio0;

  // Model: who owns the port (-1 = nobody), pops in this burst, next RR start.
  int m_owner;
  int m_pops;
  int m_rr;

  logic [NUM_REQ-1:0]    obs_valid, obs_gnt, exp_valid, exp_gnt;
  logic                  obs_inc, obs_busy, exp_inc, exp_busy;
  logic [DATA_WIDTH-1:0] obs_data;

  function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_pops  = 0;
    m_rr    = 0;
  endtask

  task automatic model_outputs();
    exp_valid = '0;
    exp_gnt   = '0;
    exp_inc   = 1'b0;
    exp_busy  = 1'b0;
    if (rst_n && m_owner >= 0) begin
      exp_gnt[m_owner] = 1'b1;
      exp_busy         = 1'b1;
      if (req[m_owner] && fifo_q.size() != 0) begin
        exp_valid[m_owner] = 1'b1;
        exp_inc            = rdy[m_owner];
      end
    end
  endtask

  task automatic model_advance();
    if (!rst_n) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (req != '0 && fifo_q.size() != 0) begin
        if (prio0 && req[0]) m_owner = 0;
        else
          for (int k = 0; k < NUM_REQ; k++)
            if (m_owner < 0 && req[(m_rr + k) % NUM_REQ]) m_owner = (m_rr + k) % NUM_REQ;
        m_pops = 0;
      end
    end else begin
      if (exp_inc) m_pops++;
      if (m_pops == BURST_LEN || !req[m_owner] || fifo_q.size() == 0) begin
        if (!(prio0 && m_owner == 0)) m_rr = (m_owner + 1) % NUM_REQ;
        m_owner = -1;
        m_pops  = 0;
      end
    end
  endtask

  // One clock: present FIFO state, sample DUT and model, advance across the edge.
  task automatic tick();
    r_empty = (fifo_q.size() == 0);
    rd_data = r_empty ? DATA_WIDTH'($urandom) : fifo_q[0];
    #2;
    obs_valid = valid;
    obs_gnt   = gnt;
    obs_inc   = r_inc;
    obs_busy  = busy;
    obs_data  = data;
    model_outputs();
    @(posedge clk);
    model_advance();
    if (obs_inc && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    fifo_q.delete();
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(DATA_WIDTH'($urandom));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    req = 4'b1111;
    rdy = 4'b1111;
    fifo_q.delete();
    fill(3);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if ({obs_gnt, obs_inc, obs_valid, obs_busy} !== '0) begin
        n_errors++;
        $display("FAIL reset_hold: gnt=%b inc=%b valid=%b busy=%b, all must be 0", obs_gnt, obs_inc, obs_valid, obs_busy);
      end
    end
    n_checks++;
    if (fifo_q.size() != 3) begin
      n_errors++;
      $display("FAIL reset_no_pop: fifo holds %0d words, expected 3", fifo_q.size());
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_first_grant: gnt=%b expected 0001", gnt);
    end
  endtask

  task automatic test_rr_order();
    int owners[$];
    int ticks = 0;
    do_reset();
    fill(16);
    req = 4'b1111;
    rdy = 4'b1111;
    while (owners.size() < 16 && ticks < 40) begin
      tick();
      ticks++;
      n_checks++;
      if ({obs_valid, obs_inc, obs_gnt, obs_busy, obs_data} !== {exp_valid, exp_inc, exp_gnt, exp_busy, rd_data}) begin
        n_errors++;
        $display("FAIL rr_cycle: valid=%b inc=%b gnt=%b busy=%b data=%h, expected %b %b %b %b %h",
                 obs_valid, obs_inc, obs_gnt, obs_busy, obs_data, exp_valid, exp_inc, exp_gnt, exp_busy, rd_data);
      end
      if (obs_inc) owners.push_back(oh_idx(obs_gnt));
    end
    n_checks++;
    if (ticks != 20 || owners.size() != 16) begin
      n_errors++;
      $display("FAIL rr_timing: %0d pops in %0d cycles, expected 16 pops in 20 cycles", owners.size(), ticks);
    end
    for (int i = 0; i < owners.size(); i++) begin
      n_checks++;
      if (owners[i] != i / BURST_LEN) begin
        n_errors++;
        $display("FAIL rr_order: pop %0d went to %0d, expected %0d", i, owners[i], i / BURST_LEN);
      end
    end
  endtask

  task automatic test_empty_exit();
    int pops;
    do_reset();
    fill(2);
    req = 4'b0100;
    rdy = 4'b1111;
    pops = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if ({obs_valid, obs_inc, obs_gnt, obs_busy} !== {exp_valid, exp_inc, exp_gnt, exp_busy}) begin
        n_errors++;
        $display("FAIL empty_cycle: valid=%b inc=%b gnt=%b busy=%b, expected %b %b %b %b",
                 obs_valid, obs_inc, obs_gnt, obs_busy, exp_valid, exp_inc, exp_gnt, exp_busy);
      end
      if (obs_inc) pops++;
    end
    n_checks++;
    if (pops != 2 || gnt !== 4'b0000 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_exit: pops=%0d gnt=%b busy=%b, expected 2 pops then idle", pops, gnt, busy);
    end
    fill(1);
    pops = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (obs_inc) begin
        pops++;
        n_checks++;
        if (obs_gnt !== 4'b0100) begin
          n_errors++;
          $display("FAIL refill_grant: pop with gnt=%b, expected 0100", obs_gnt);
        end
      end
    end
    n_checks++;
    if (pops != 1) begin
      n_errors++;
      $display("FAIL refill_pops: %0d pops, expected 1", pops);
    end
  endtask

  task automatic test_stall();
    int pops;
    do_reset();
    fill(8);
    req = 4'b0010;
    rdy = 4'b0000;
    tick();
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (obs_valid !== 4'b0010 || obs_inc !== 1'b0) begin
        n_errors++;
        $display("FAIL stall_hold: valid=%b inc=%b, expected valid=0010 inc=0", obs_valid, obs_inc);
      end
    end
    rdy  = 4'b1111;
    pops = 0;
    for (int c = 0; c < 10 && busy; c++) begin
      tick();
      if (obs_inc) pops++;
    end
    n_checks++;
    if (pops != BURST_LEN || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_release: pops=%0d busy=%b, expected %0d pops then idle", pops, busy, BURST_LEN);
    end
  endtask

  task automatic test_drop();
    do_reset();
    fill(8);
    req = 4'b1000;
    rdy = 4'b1111;
    tick();
    tick();
    n_checks++;
    if (obs_inc !== 1'b1 || obs_gnt !== 4'b1000) begin
      n_errors++;
      $display("FAIL drop_first_pop: inc=%b gnt=%b, expected 1 1000", obs_inc, obs_gnt);
    end
    req = 4'b0001;
    tick();
    n_checks++;
    if (obs_inc !== 1'b0 || gnt !== 4'b0000) begin
      n_errors++;
      $display("FAIL drop_exit: inc=%b gnt_after=%b, expected 0 0000", obs_inc, gnt);
    end
    req = 4'b1001;
    tick();
    n_checks++;
    if (gnt !== 4'b0001) begin
      n_errors++;
      $display("FAIL drop_next_grant: gnt=%b expected 0001", gnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fill(6);
    req = 4'b0001;
    rdy = 4'b1111;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({gnt, r_inc, valid, busy} !== '0) begin
      n_errors++;
      $display("FAIL async_reset: gnt=%b inc=%b valid=%b busy=%b, all must be 0", gnt, r_inc, valid, busy);
    end
    tick();
    n_checks++;
    if (obs_inc !== 1'b0 || fifo_q.size() != 5) begin
      n_errors++;
      $display("FAIL reset_pop: inc=%b words=%0d, expected 0 and 5", obs_inc, fifo_q.size());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_prio0();
    int owners[$];
    int ticks = 0;
    do_reset();
    fill(12);
    req = 4'b0101;
    rdy = 4'b1111;
    while (owners.size() < 12 && ticks < 40) begin
      tick();
      ticks++;
      if (obs_inc) owners.push_back(oh_idx(obs_gnt));
    end
    n_checks++;
    if (ticks != 15 || owners.size() != 12) begin
      n_errors++;
      $display("FAIL prio0_timing: %0d pops in %0d cycles, expected 12 in 15", owners.size(), ticks);
    end
    foreach (owners[i]) begin
      n_checks++;
      if (owners[i] != 0) begin
        n_errors++;
        $display("FAIL prio0_owner: pop %0d went to %0d, expected 0", i, owners[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    req = '0;
    rdy = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) req = NUM_REQ'($urandom);
      for (int i = 0; i < NUM_REQ; i++) rdy[i] = ($urandom_range(3) != 0);
      if (fifo_q.size() < 10 && $urandom_range(4) < 2) fill(1);
      tick();
      n_checks++;
      if ({obs_valid, obs_inc, obs_gnt, obs_busy, obs_data} !== {exp_valid, exp_inc, exp_gnt, exp_busy, rd_data}) begin
        n_errors++;
        $display("FAIL random_cycle %0d: valid=%b inc=%b gnt=%b busy=%b data=%h, expected %b %b %b %b %h",
                 c, obs_valid, obs_inc, obs_gnt, obs_busy, obs_data, exp_valid, exp_inc, exp_gnt, exp_busy, rd_data);
      end
    end
  endtask

  initial begin
`ifdef FIFO_RD_ARB_PRIO0_EN
    prio0 = 1'b1;
`else
    prio0 = 1'b0;
`endif
    rst_n   = 1'b0;
    req     = '0;
    rdy     = '0;
    r_empty = 1'b1;
    rd_data = '0;
    model_reset();
    test_reset();
    test_empty_exit();
    test_stall();
    test_drop();
    test_async_reset();
`ifdef FIFO_RD_ARB_PRIO0_EN
    test_prio0();
`else
    test_rr_order();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Read-port arbiter for the asynchronous FIFO. It sits in the read clock domain between the FIFO read-side controller and up to NUM_REQ consumers, and shares the single pop interface among them. Grants are round-robin and held for bounded bursts. It drives the FIFO read-increment strobe and forwards the first-word-fall-through read data to the granted consumer under a valid/ready handshake.

## Interface
- NUM_REQ, 4 — number of consumers, 2..8.
- DATA_WIDTH, 8 — FIFO word width.
- BURST_LEN, 4 — maximum pops per grant, ≥1.
- i_r_clk  in  1  read-domain clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_r_empty  in  1  FIFO empty flag from the read-side controller.
- i_rd_data  in  DATA_WIDTH  FIFO head word, valid whenever i_r_empty=0.
- i_req  in  NUM_REQ  per-consumer request, level.
- i_rdy  in  NUM_REQ  per-consumer ready.
- o_r_inc  out  1  pop strobe to the FIFO read controller.
- o_valid  out  NUM_REQ  per-consumer data valid, one-hot or zero.
- o_data  out  DATA_WIDTH  equals i_rd_data (shared bus).
- o_gnt  out  NUM_REQ  registered one-hot grant.
- o_busy  out  1  high in BURST.

## Operation
- States are IDLE and BURST. Reset values: state=IDLE, o_gnt=0, rr_ptr=0, burst count=0. All outputs reset low except o_data, which follows i_rd_data.
- IDLE:
  - If any i_req and i_r_empty=0, pick the winner by rotating-priority search starting at rr_ptr.
  - Register o_gnt=one-hot(winner) and count=0, then go to BURST.
  - Otherwise stay in IDLE.
- BURST, granted index g:
  - o_valid[g] = i_req[g] & ~i_r_empty.
  - Transfer = o_valid[g] & i_rdy[g].
  - o_r_inc = transfer, purely combinational from registered grant and inputs.
  - Each transfer increments count.
- Exit BURST to IDLE on the first of these:
  - A transfer with count=BURST_LEN-1.
  - i_req[g]=0.
  - i_r_empty=1.
- On exit: o_gnt←0, rr_ptr←(g+1) mod NUM_REQ, count←0.
- o_r_inc is never asserted when i_r_empty=1 or in IDLE. At most one pop per cycle.
- A consumer that holds i_rdy=0 with i_req=1 stalls its burst. There is no timeout; the consumer must drop i_req to yield.
- Count width is clog2(BURST_LEN)+1. It never wraps, because exit occurs at BURST_LEN-1.
- Non-granted consumers see o_valid=0 regardless of their i_req.

## Timing
- Arbitration latency: i_req rises in cycle n with FIFO non-empty → o_gnt in cycle n+1, first pop possible in n+1.
- Back-to-back grant: after exit in cycle m, IDLE in m+1, the next grant is visible in m+2. There is one idle bubble per rearbitration.
- A full BURST_LEN burst with continuous ready takes BURST_LEN cycles in BURST.
- i_r_empty rising in a BURST cycle: o_valid and o_r_inc stay low that cycle, and the state is IDLE next cycle.
- Reset asserted mid-burst: outputs go low asynchronously. No pop is issued during reset.

## Configuration
- FIFO_RD_ARB_PRIO0_EN defined: in IDLE, consumer 0 wins whenever it requests, and rr_ptr is ignored for that decision. Its bursts still end at BURST_LEN, and rr_ptr is not updated when consumer 0's burst ends.
- Undefined: pure round-robin across all consumers.

## Structure
- Package fifo_rd_arb_pkg holds:
  - the state enum (ST_IDLE, ST_BURST);
  - the count-width localparam function;
  - the one-hot-to-index function.
- One sub-module, rr_pick: a combinational rotating-priority picker with inputs req[NUM_REQ] and start index, and outputs one-hot winner and any.

## Test plan
- Reset with i_req=4'b1111, FIFO holding 3 words → o_gnt=0, o_r_inc=0 during reset. After release, o_gnt=4'b0001 one cycle after the first edge.
- All four request continuously, FIFO holds 16 words, all ready, BURST_LEN=4 → grants in order 0,1,2,3, each exactly 4 pops, with one idle cycle between grants.
- Consumer 2 alone, FIFO runs empty after 2 words → 2 pops, then state returns to IDLE. Refill with 1 word → regrant to 2 and 1 pop.
- Consumer 1 granted with i_rdy[1]=0 for 5 cycles → o_valid[1]=1 and o_r_inc=0 throughout. Then i_rdy=1 → 4 pops.
- Consumer 3 drops i_req after 1 pop → exit and rr_ptr=0, so consumer 0 is granted next.
- FIFO_RD_ARB_PRIO0_EN defined, consumers 0 and 2 requesting → consumer 0 wins every arbitration, with a 4-pop burst each time.
